// File: rtl/membus_arbiter_if.sv
// membus request/response bundle. N lanes of valid/ready/payload share one
// rdata bus; rvalid is per lane. The arbiter takes an N-lane bundle from the
// masters (slave view) and drives a 1-lane bundle to the memory (master view).
interface membus_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [N-1:0]                valid;
    logic [N-1:0]                ready;
    logic [N*ADDR_WIDTH-1:0]     addr;
    logic [N-1:0]                wen;
    logic [N*DATA_WIDTH-1:0]     wdata;
    logic [N*DATA_WIDTH/8-1:0]   wmask;
    logic [N-1:0]                rvalid;
    logic [DATA_WIDTH-1:0]       rdata;

    // Handshake: a request lane transfers on a cycle where valid and ready are
    // both high; the requester holds valid and payload stable until then. Each
    // transfer, read or write, is answered by exactly one rvalid pulse, in order.
    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/membus_arbiter.sv
// N-master to 1-slave membus arbiter. Grants one requester per handshake
// (round-robin or fixed priority), holds the grant while the slave stalls,
// and routes in-order responses back through a FIFO of granted master IDs.
module membus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit FIXED_PRIORITY  = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    membus_arbiter_if.slave                      m,
    membus_arbiter_if.master                     s,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 resp_err
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int WW = DATA_WIDTH / 8;
    // FIFO pointer width; a depth-1 FIFO gets a 2-slot array whose pointers
    // toggle, which behaves as depth 1 because cnt never exceeds 1.
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FD = 1 << PW;

    logic [IW-1:0] rr_ptr_q;
    logic          lock_q;
    logic [IW-1:0] lock_id_q;
    logic [IW-1:0] fifo_q [FD];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          resp_err_q;

    logic [IW-1:0] grant;
    logic [IW-1:0] next_rr;
    logic [IW-1:0] head_id;
    logic          any_valid, full, empty, issue, push, pop;

    // Grant selection: a held grant wins; otherwise search for the winner.
    // Loops run downward so the last match written is the preferred one.
    always_comb begin
        grant = lock_id_q;
        if (!lock_q) begin
            grant = '0;
            if (FIXED_PRIORITY) begin
                for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                    if (m.valid[i]) grant = IW'(i);
                end
            end else begin
                for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                    if (m.valid[(int'(rr_ptr_q) + k) % NUM_MASTERS])
                        grant = IW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
                end
            end
        end
    end

    assign any_valid = |m.valid;
    assign full      = (cnt_q == CW'(MAX_OUTSTANDING));
    assign empty     = (cnt_q == '0);
    // Gated by rst_n so nothing is offered to the slave while held in reset.
    assign issue     = rst_n & any_valid & ~full;
    assign push      = issue & s.ready[0];
    assign pop       = s.rvalid[0] & ~empty;
    assign head_id   = fifo_q[rd_ptr_q];
    assign next_rr   = IW'((int'(grant) + 1) % NUM_MASTERS);

    // Issue path: forward the granted master's request slices to the slave.
    assign s.valid[0] = issue;
    assign s.addr     = m.addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s.wen[0]   = m.wen[grant];
    assign s.wdata    = m.wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign s.wmask    = m.wmask[int'(grant)*WW +: WW];

    // Accept strobe to the granted master only.
    always_comb begin
        m.ready = '0;
        if (push) m.ready[grant] = 1'b1;
    end

    // Response routing: the FIFO head names the master this response belongs to.
    always_comb begin
        m.rvalid = '0;
        if (pop) m.rvalid[head_id] = 1'b1;
    end

    assign m.rdata = s.rdata;

    // In-flight counter: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Arbitration state, ID FIFO, counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
            for (int i = 0; i < FD; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= grant;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
                rr_ptr_q         <= next_rr;
                lock_q           <= 1'b0;
            end else if (issue) begin
                // Slave stalled: freeze the grant so the request it sees is stable.
                lock_q    <= 1'b1;
                lock_id_q <= grant;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
            if (s.rvalid[0] && empty) resp_err_q <= 1'b1;
        end
    end

    assign outstanding = cnt_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: a 2-master round-robin instance and a
// 3-master fixed-priority instance, both with a 4-deep ID FIFO.
module tb_membus_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] rr_out, fp_out;
    logic          rr_err, fp_err;

    int n_checks = 0;
    int n_fail   = 0;

    membus_arbiter_if #(.N(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rr_m ();
    membus_arbiter_if #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rr_s ();
    membus_arbiter_if #(.N(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fp_m ();
    membus_arbiter_if #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fp_s ();

    membus_arbiter #(
        .NUM_MASTERS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MAX_OUTSTANDING(MO), .FIXED_PRIORITY(1'b0)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n), .m(rr_m), .s(rr_s),
        .outstanding(rr_out), .resp_err(rr_err)
    );

    membus_arbiter #(
        .NUM_MASTERS(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MAX_OUTSTANDING(MO), .FIXED_PRIORITY(1'b1)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n), .m(fp_m), .s(fp_s),
        .outstanding(fp_out), .resp_err(fp_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Idle inputs and fixed payloads
        rst_n        = 1'b1;
        rr_m.valid   = 2'b00;
        rr_m.addr    = {32'h0000_0200, 32'h0000_0100};
        rr_m.wen     = 2'b10;
        rr_m.wdata   = {32'hBBBB_0001, 32'hAAAA_0000};
        rr_m.wmask   = {4'hC, 4'h3};
        rr_s.ready   = 1'b0;
        rr_s.rvalid  = 1'b0;
        rr_s.rdata   = '0;
        fp_m.valid   = 3'b000;
        fp_m.addr    = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        fp_m.wen     = 3'b000;
        fp_m.wdata   = '0;
        fp_m.wmask   = '0;
        fp_s.ready   = 1'b0;
        fp_s.rvalid  = 1'b0;
        fp_s.rdata   = '0;

        // Reset with request and response inputs active: outputs forced low
        #1 rst_n = 1'b0;
        rr_m.valid  = 2'b11;
        rr_s.ready  = 1'b1;
        rr_s.rvalid = 1'b1;
        #2;
        check("rst_s_valid", rr_s.valid, 1'b0);
        check("rst_m_ready", rr_m.ready, 2'b00);
        check("rst_m_rvalid", rr_m.rvalid, 2'b00);
        check("rst_outstanding", rr_out, 3'd0);
        check("rst_resp_err", rr_err, 1'b0);
        rr_m.valid  = 2'b00;
        rr_s.rvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Round-robin: both masters valid, responses two cycles after accept
        rr_m.valid = 2'b11;
        rr_s.ready = 1'b1;
        #1;
        check("rr0_ready", rr_m.ready, 2'b01);
        check("rr0_addr", rr_s.addr, 32'h100);
        check("rr0_rvalid", rr_m.rvalid, 2'b00);
        tick();
        #1;
        check("rr1_ready", rr_m.ready, 2'b10);
        check("rr1_addr", rr_s.addr, 32'h200);
        check("rr1_wdata", rr_s.wdata, 32'hBBBB_0001);
        check("rr1_wen", rr_s.wen, 1'b1);
        check("rr1_wmask", rr_s.wmask, 4'hC);
        check("rr1_out", rr_out, 3'd1);
        tick();
        rr_s.rvalid = 1'b1;
        rr_s.rdata  = 32'hA0;
        #1;
        check("rr2_ready", rr_m.ready, 2'b01);
        check("rr2_rvalid", rr_m.rvalid, 2'b01);
        check("rr2_rdata", rr_m.rdata, 32'hA0);
        check("rr2_out", rr_out, 3'd2);
        tick();
        rr_s.rdata = 32'hA1;
        #1;
        check("rr3_ready", rr_m.ready, 2'b10);
        check("rr3_rvalid", rr_m.rvalid, 2'b10);
        check("rr3_rdata", rr_m.rdata, 32'hA1);
        check("rr3_out", rr_out, 3'd2);
        tick();
        rr_m.valid = 2'b00;
        rr_s.rdata = 32'hA2;
        #1;
        check("rr4_s_valid", rr_s.valid, 1'b0);
        check("rr4_rvalid", rr_m.rvalid, 2'b01);
        tick();
        rr_s.rdata = 32'hA3;
        #1;
        check("rr5_rvalid", rr_m.rvalid, 2'b10);
        check("rr5_out", rr_out, 3'd1);
        tick();
        rr_s.rvalid = 1'b0;
        #1;
        check("rr6_out", rr_out, 3'd0);
        tick();

        // Lock on stall: master 1 stalls three cycles, master 0 then joins
        rr_m.valid = 2'b10;
        rr_s.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lk_stall_addr", rr_s.addr, 32'h200);
            check("lk_stall_valid", rr_s.valid, 1'b1);
            check("lk_stall_ready", rr_m.ready, 2'b00);
            tick();
        end
        rr_m.valid = 2'b11;
        #1;
        check("lk3_addr", rr_s.addr, 32'h200);
        check("lk3_ready", rr_m.ready, 2'b00);
        tick();
        rr_s.ready = 1'b1;
        #1;
        check("lk4_addr", rr_s.addr, 32'h200);
        check("lk4_ready", rr_m.ready, 2'b10);
        tick();
        rr_m.valid = 2'b01;
        #1;
        check("lk5_addr", rr_s.addr, 32'h100);
        check("lk5_ready", rr_m.ready, 2'b01);
        tick();
        rr_m.valid  = 2'b00;
        rr_s.rvalid = 1'b1;
        rr_s.rdata  = 32'hB0;
        #1;
        check("lk6_rvalid", rr_m.rvalid, 2'b10);
        check("lk6_rdata", rr_m.rdata, 32'hB0);
        tick();
        rr_s.rdata = 32'hB1;
        #1;
        check("lk7_rvalid", rr_m.rvalid, 2'b01);
        tick();
        rr_s.rvalid = 1'b0;
        #1;
        check("lk8_out", rr_out, 3'd0);
        tick();

        // Full FIFO: four accepts with no responses
        rr_m.valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fl_fill_ready", rr_m.ready, 2'b01);
            tick();
        end
        #1;
        check("fl_full_out", rr_out, 3'd4);
        check("fl_full_s_valid", rr_s.valid, 1'b0);
        check("fl_full_ready", rr_m.ready, 2'b00);
        tick();
        rr_s.rvalid = 1'b1;
        rr_s.rdata  = 32'hC0;
        #1;
        check("fl_pop_s_valid", rr_s.valid, 1'b0);
        check("fl_pop_rvalid", rr_m.rvalid, 2'b01);
        check("fl_pop_out", rr_out, 3'd4);
        tick();
        rr_s.rvalid = 1'b0;
        #1;
        check("fl_resume_out", rr_out, 3'd3);
        check("fl_resume_s_valid", rr_s.valid, 1'b1);
        check("fl_resume_ready", rr_m.ready, 2'b01);
        tick();
        rr_m.valid = 2'b00;
        #1;
        check("fl_refill_out", rr_out, 3'd4);
        tick();
        rr_s.rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fl_drain_rvalid", rr_m.rvalid, 2'b01);
            tick();
        end

        // Response with the FIFO empty: dropped and flagged
        #1;
        check("er_rvalid", rr_m.rvalid, 2'b00);
        check("er_err_before", rr_err, 1'b0);
        check("er_out", rr_out, 3'd0);
        tick();
        rr_s.rvalid = 1'b0;
        #1;
        check("er_err_sticky", rr_err, 1'b1);
        check("er_out_no_wrap", rr_out, 3'd0);
        tick();

        // Reset with two master-1 requests outstanding
        rr_m.valid = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rs_fill_ready", rr_m.ready, 2'b10);
            tick();
        end
        rr_m.valid = 2'b00;
        #1;
        check("rs_out_before", rr_out, 3'd2);
        rst_n       = 1'b0;
        rr_m.valid  = 2'b11;
        rr_s.rvalid = 1'b1;
        #1;
        check("rs_out", rr_out, 3'd0);
        check("rs_err", rr_err, 1'b0);
        check("rs_s_valid", rr_s.valid, 1'b0);
        check("rs_ready", rr_m.ready, 2'b00);
        check("rs_rvalid", rr_m.rvalid, 2'b00);
        tick();
        rr_m.valid  = 2'b00;
        rr_s.rvalid = 1'b0;
        rst_n       = 1'b1;
        tick();
        rr_m.valid = 2'b01;
        #1;
        check("rs_new_ready", rr_m.ready, 2'b01);
        check("rs_new_out", rr_out, 3'd0);
        tick();
        rr_m.valid  = 2'b00;
        rr_s.rvalid = 1'b1;
        rr_s.rdata  = 32'hD0;
        #1;
        // Stale master-1 IDs were discarded, so this response goes to master 0
        check("rs_new_rvalid", rr_m.rvalid, 2'b01);
        check("rs_new_rdata", rr_m.rdata, 32'hD0);
        tick();
        rr_s.rvalid = 1'b0;
        #1;
        check("rs_end_out", rr_out, 3'd0);
        check("rs_end_err", rr_err, 1'b0);
        tick();

        // Fixed priority: master 0 wins until it drops, then 1, then 2
        fp_m.valid = 3'b111;
        fp_s.ready = 1'b1;
        #1;
        check("fp0_ready", fp_m.ready, 3'b001);
        check("fp0_addr", fp_s.addr, 32'h100);
        tick();
        fp_s.rvalid = 1'b1;
        fp_s.rdata  = 32'hE0;
        #1;
        check("fp1_ready", fp_m.ready, 3'b001);
        check("fp1_rvalid", fp_m.rvalid, 3'b001);
        tick();
        fp_m.valid = 3'b110;
        fp_s.rdata = 32'hE1;
        #1;
        check("fp2_ready", fp_m.ready, 3'b010);
        check("fp2_addr", fp_s.addr, 32'h200);
        check("fp2_rvalid", fp_m.rvalid, 3'b001);
        tick();
        fp_m.valid = 3'b100;
        fp_s.rdata = 32'hE2;
        #1;
        check("fp3_ready", fp_m.ready, 3'b100);
        check("fp3_addr", fp_s.addr, 32'h300);
        check("fp3_rvalid", fp_m.rvalid, 3'b010);
        check("fp3_rdata", fp_m.rdata, 32'hE2);
        tick();
        fp_m.valid = 3'b000;
        fp_s.rdata = 32'hE3;
        #1;
        check("fp4_s_valid", fp_s.valid, 1'b0);
        check("fp4_rvalid", fp_m.rvalid, 3'b100);
        tick();
        fp_s.rvalid = 1'b0;
        #1;
        check("fp5_out", fp_out, 3'd0);
        check("fp5_err", fp_err, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Parametrised N-master to 1-slave arbiter for the membus valid/ready request, rvalid/rdata response protocol. It sits between the core's fetch and load/store ports and the shared memory or bus slave. It grants one requester per handshake, in round-robin or fixed-priority mode, and holds the grant stable while the slave stalls. A FIFO of granted master IDs routes each in-order response back to its requester, with up to MAX_OUTSTANDING requests in flight.

## Interface
- NUM_MASTERS, 2: requester count, 2..8
- DATA_WIDTH, MEMBUS_DATA_WIDTH: wdata/rdata width, multiple of 8
- ADDR_WIDTH, XLEN: address width
- MAX_OUTSTANDING, 4: ID FIFO depth, power of two, ≥1
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = fixed priority, lowest index wins
- Widths: IW = max(1, $clog2(NUM_MASTERS)); CW = $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- m_valid  in  NUM_MASTERS  per-master request valid
- m_ready  out  NUM_MASTERS  per-master request accepted
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at slice i
- m_wen  in  NUM_MASTERS  write enable
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  write data
- m_wmask  in  NUM_MASTERS*DATA_WIDTH/8  byte mask
- m_rvalid  out  NUM_MASTERS  response valid, one-hot or zero
- m_rdata  out  DATA_WIDTH  response data, shared by all masters
- s_valid, s_addr, s_wen, s_wdata, s_wmask  out  matching widths  request to slave
- s_ready  in  1  slave accepts
- s_rvalid  in  1  slave response valid
- s_rdata  in  DATA_WIDTH  slave response data
- outstanding  out  CW  number of accepted requests awaiting a response
- resp_err  out  1  sticky flag: s_rvalid arrived with the ID FIFO empty

## Operation

**Protocol**
- A master holds valid and its payload stable until it sees ready.
- Every accepted request, read or write, produces exactly one s_rvalid pulse.
- Responses return in acceptance order.

**State**
- rr_ptr (IW bits): round-robin pointer.
- lock (1 bit) and lock_id (IW bits): held grant.
- ID FIFO: MAX_OUTSTANDING entries of IW bits.
- cnt (CW bits) and resp_err.

**Grant selection**
- If lock = 1, grant = lock_id.
- Else, in round-robin mode: the first i with m_valid[i] = 1, searching from rr_ptr upward modulo NUM_MASTERS.
- Else, in fixed-priority mode: the lowest i with m_valid[i] = 1.
- `any` = OR of m_valid.

**Issue path (combinational)**
- full = (cnt == MAX_OUTSTANDING).
- s_valid = any & ~full.
- s_addr, s_wen, s_wdata and s_wmask mux the granted master's slices.
- m_ready[i] = (i == grant) & s_valid & s_ready.

**Handshake** (s_valid & s_ready):
- Push grant into the FIFO.
- rr_ptr ← (grant + 1) mod NUM_MASTERS.
- lock ← 0.

**Stall** (s_valid & ~s_ready): lock ← 1, lock_id ← grant. The slave therefore never sees the address or master change while its valid is held.

**Response path**
- On s_rvalid with the FIFO non-empty: pop the head ID, m_rvalid[head] = 1, m_rdata = s_rdata. This is combinational, with no added latency.
- On s_rvalid with the FIFO empty: all m_rvalid stay 0 and resp_err ← 1. resp_err clears only on reset.

**Counter**
- cnt += push − pop.
- Push and pop in the same cycle leave cnt unchanged.
- outstanding = cnt.

**Boundaries**
- Full: no issue, even if a pop occurs in the same cycle. Issue resumes the cycle after cnt drops.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- Push and pop in the same cycle at cnt = 1: the FIFO is valid afterwards, and the popped ID is the older entry.
- NUM_MASTERS = 1: grant is always 0 and rr_ptr is unused.

**Reset**
- While rst_n = 0, the following are forced 0: s_valid, m_ready, m_rvalid, outstanding, resp_err.
- Registers take these values: rr_ptr = 0, lock = 0, lock_id = 0, FIFO empty, cnt = 0.
- Reset asserted mid-transaction discards all in-flight IDs. The slave shares the same reset.

## Timing
- Request path is zero-latency: a handshake occurs in the same cycle that m_valid and s_ready are high and the FIFO is not full.
- Response path is zero-latency: s_rvalid appears at m_rvalid in the same cycle.
- The slave asserts s_rvalid no earlier than the cycle after the corresponding accept. A same-cycle response is treated as an empty-FIFO error.
- Throughput is one request per cycle while s_ready = 1 and the FIFO is not full.
- Grant, rr_ptr, lock and the FIFO update on the rising edge of clk only.

## Test plan
- Round-robin: NUM_MASTERS = 2, both masters valid continuously, s_ready = 1, response 2 cycles after accept. Required: grants alternate 0,1,0,1; each m_rvalid pulse goes to the master granted two cycles earlier; rdata = slave tag.
- Lock on stall: master 1 valid with s_ready = 0 for 3 cycles, then master 0 raises valid. Required: s_addr stays at master 1's address until s_ready = 1; master 0 is granted the next cycle.
- Full FIFO: MAX_OUTSTANDING = 4, 4 accepts, no responses. Required: outstanding = 4 and s_valid = 0. One s_rvalid → outstanding = 3; s_valid = 1 on the following cycle.
- Fixed priority: FIXED_PRIORITY = 1, NUM_MASTERS = 3, all valid. Required: master 0 is granted every cycle and masters 1 and 2 are starved until m_valid[0] drops.
- Error and reset: s_rvalid with the FIFO empty → resp_err = 1, all m_rvalid = 0. Then rst_n low with 2 requests outstanding → outstanding = 0, resp_err = 0, no m_rvalid after release.
